// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: turns the UART receive byte stream into framed game commands.
// Frame layout is SYNC, CMD, LEN, LEN payload bytes, CHK, where CHK = CMD ^ LEN ^ payload.
// A good frame is delivered through a one-entry valid/ready holding register.
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned MAX_LEN      = 4,
    parameter int unsigned TIMEOUT_CLKS = 43400,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_DV,
    input  logic [7:0]           i_Rx_Byte,
    output logic                 o_Cmd_Valid,
    input  logic                 i_Cmd_Ready,
    output logic [7:0]           o_Cmd,
    output logic [2:0]           o_Len,
    output logic [8*MAX_LEN-1:0] o_Payload,
    output logic                 o_Err_Chk,
    output logic                 o_Err_Len,
    output logic                 o_Err_Timeout,
    output logic                 o_Err_Overrun,
    output logic                 o_Busy
);

    localparam int unsigned      PAY_W     = 8 * MAX_LEN;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_PAY  = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_cmd_stage;
    logic [2:0]         r_len_stage;
    logic [2:0]         r_idx;
    logic [7:0]         r_chk;
    logic [PAY_W-1:0]   r_pay_stage;

    logic               r_cmd_valid;
    logic [7:0]         r_cmd;
    logic [2:0]         r_len;
    logic [PAY_W-1:0]   r_payload;
    logic               r_err_chk;
    logic               r_err_len;
    logic               r_err_timeout;
    logic               r_err_overrun;
    logic               r_busy;

    logic               w_expire;
    logic               w_good;
    logic               w_err_len;
    logic               w_err_chk;
    logic               w_load;

    // Frame-sequencing state register
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-byte decode; a byte arriving on the expiry cycle beats the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_err_len   = 1'b0;
        w_err_chk   = 1'b0;
        w_expire    = (r_state != S_HUNT) && !i_Rx_DV && (r_cnt == CNT_LAST);
        if (w_expire) begin
            w_state_nxt = S_HUNT;
        end else if (i_Rx_DV) begin
            case (r_state)
                S_HUNT: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        w_state_nxt = S_CMD;
                    end
                end
                S_CMD: begin
                    w_state_nxt = S_LEN;
                end
                S_LEN: begin
                    if (i_Rx_Byte > MAX_LEN_B) begin
                        w_err_len   = 1'b1;
                        w_state_nxt = S_HUNT;
                    end else if (i_Rx_Byte == 8'd0) begin
                        w_state_nxt = S_CHK;
                    end else begin
                        w_state_nxt = S_PAY;
                    end
                end
                S_PAY: begin
                    if (r_idx == (r_len_stage - 3'd1)) begin
                        w_state_nxt = S_CHK;
                    end
                end
                S_CHK: begin
                    if (i_Rx_Byte == r_chk) begin
                        w_good = 1'b1;
                    end else begin
                        w_err_chk = 1'b1;
                    end
                    w_state_nxt = S_HUNT;
                end
                default: begin
                    w_state_nxt = S_HUNT;
                end
            endcase
        end
    end

    // Staging registers: command, length, payload shift and running checksum
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_cmd_stage <= 8'd0;
            r_len_stage <= 3'd0;
            r_idx       <= 3'd0;
            r_chk       <= 8'd0;
            r_pay_stage <= '0;
        end else if (i_Rx_DV) begin
            case (r_state)
                S_HUNT: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        r_pay_stage <= '0;
                        r_idx       <= 3'd0;
                    end
                end
                S_CMD: begin
                    r_cmd_stage <= i_Rx_Byte;
                    r_chk       <= i_Rx_Byte;
                end
                S_LEN: begin
                    if (i_Rx_Byte <= MAX_LEN_B) begin
                        r_len_stage <= i_Rx_Byte[2:0];
                        r_chk       <= r_chk ^ i_Rx_Byte;
                    end
                end
                S_PAY: begin
                    for (int k = 0; k < MAX_LEN; k++) begin
                        if (r_idx == 3'(k)) begin
                            r_pay_stage[8*k +: 8] <= i_Rx_Byte;
                        end
                    end
                    r_chk <= r_chk ^ i_Rx_Byte;
                    r_idx <= r_idx + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Inter-byte idle counter, held clear while hunting
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_cnt <= '0;
        end else if (i_Rx_DV || (r_state == S_HUNT) || w_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_load = w_good && (!r_cmd_valid || i_Cmd_Ready);

    // One-entry output holding register with valid/ready handshake
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd       <= 8'd0;
            r_len       <= 3'd0;
            r_payload   <= '0;
        end else if (w_load) begin
            r_cmd_valid <= 1'b1;
            r_cmd       <= r_cmd_stage;
            r_len       <= r_len_stage;
            r_payload   <= r_pay_stage;
        end else if (r_cmd_valid && i_Cmd_Ready) begin
            r_cmd_valid <= 1'b0;
        end
    end

    // Registered error pulses and busy flag
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_err_chk     <= w_err_chk;
            r_err_len     <= w_err_len;
            r_err_timeout <= w_expire;
            r_err_overrun <= w_good && !w_load;
            r_busy        <= (w_state_nxt != S_HUNT);
        end
    end

    assign o_Cmd_Valid   = r_cmd_valid;
    assign o_Cmd         = r_cmd;
    assign o_Len         = r_len;
    assign o_Payload     = r_payload;
    assign o_Err_Chk     = r_err_chk;
    assign o_Err_Len     = r_err_len;
    assign o_Err_Timeout = r_err_timeout;
    assign o_Err_Overrun = r_err_overrun;
    assign o_Busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and random frames checked every cycle against a
// queue-based frame model built from the frame rules.
module tb_uart_rx_frame_ctrl;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned TO      = 40;
    localparam logic [7:0]  SYNC    = 8'hA5;

    logic        clk;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic [2:0]  len;
    logic [31:0] payload;
    logic        err_chk;
    logic        err_len;
    logic        err_to;
    logic        err_ovr;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;
    string phase = "init";

    // model state: bytes of the frame in progress, idle cycles, expected outputs
    logic [7:0]  fb[$];
    int          idle;
    logic        m_valid;
    logic [7:0]  m_cmd;
    logic [2:0]  m_len;
    logic [31:0] m_pay;
    logic        m_echk, m_elen, m_eto, m_eovr, m_busy;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE    (SYNC),
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TO),
        .CNT_W        (16)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Cmd_Valid   (cmd_valid),
        .i_Cmd_Ready   (cmd_ready),
        .o_Cmd         (cmd),
        .o_Len         (len),
        .o_Payload     (payload),
        .o_Err_Chk     (err_chk),
        .o_Err_Len     (err_len),
        .o_Err_Timeout (err_to),
        .o_Err_Overrun (err_ovr),
        .o_Busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {15'd0, cmd_valid, cmd, len, payload, err_chk, err_len, err_to, err_ovr, busy};
    endfunction

    function automatic logic [63:0] model_vec();
        return {15'd0, m_valid, m_cmd, m_len, m_pay, m_echk, m_elen, m_eto, m_eovr, m_busy};
    endfunction

    task automatic model_reset();
        fb.delete();
        idle = 0;
        m_valid = 0; m_cmd = 0; m_len = 0; m_pay = 0;
        m_echk = 0; m_elen = 0; m_eto = 0; m_eovr = 0; m_busy = 0;
    endtask

    // one clock of the frame model, given the inputs sampled at that edge
    task automatic model_clk(input logic dv, input logic [7:0] b, input logic rdy);
        logic        good;
        logic [7:0]  x, gc;
        logic [2:0]  gl;
        logic [31:0] gp;
        int          n;
        good = 0; gc = 0; gl = 0; gp = 0;
        m_echk = 0; m_elen = 0; m_eto = 0; m_eovr = 0;
        if (dv) begin
            idle = 0;
            if (fb.size() == 0) begin
                if (b == SYNC) fb.push_back(b);
            end else if (fb.size() < 2) begin
                fb.push_back(b);
            end else if (fb.size() == 2) begin
                if (b > 8'(MAX_LEN)) begin
                    m_elen = 1;
                    fb.delete();
                end else begin
                    fb.push_back(b);
                end
            end else begin
                n = int'(fb[2]);
                if (fb.size() < 3 + n) begin
                    fb.push_back(b);
                end else begin
                    x = 8'd0;
                    for (int i = 1; i < fb.size(); i++) x = x ^ fb[i];
                    if (x == b) begin
                        good = 1;
                        gc = fb[1];
                        gl = 3'(n);
                        for (int k = 0; k < n; k++) gp[8*k +: 8] = fb[3+k];
                    end else begin
                        m_echk = 1;
                    end
                    fb.delete();
                end
            end
        end else if (fb.size() != 0) begin
            idle++;
            if (idle >= TO) begin
                m_eto = 1;
                fb.delete();
                idle = 0;
            end
        end
        if (good) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_cmd = gc; m_len = gl; m_pay = gp;
            end else begin
                m_eovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_busy = (fb.size() != 0);
    endtask

    task automatic step(input logic dv, input logic [7:0] b, input logic rdy);
        @(negedge clk);
        rx_dv = dv; rx_byte = b; cmd_ready = rdy;
        @(posedge clk);
        model_clk(dv, b, rdy);
        #1;
        check_eq(phase, dut_vec(), model_vec());
    endtask

    function automatic logic pick_rdy();
        if (rdy_mode == 1) return 1'b1;
        if (rdy_mode == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic sendb(input logic [7:0] b);
        step(1'b1, b, pick_rdy());
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(1'b0, 8'h00, pick_rdy());
    endtask

    task automatic random_frame();
        logic [7:0] q[$];
        logic [7:0] x;
        int kind, ln, pos, gap;
        kind = $urandom_range(0, 9);
        ln = $urandom_range(0, MAX_LEN);
        q.push_back(SYNC);
        q.push_back(8'($urandom));
        if (kind == 1) begin
            q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
        end else begin
            q.push_back(8'(ln));
            for (int i = 0; i < ln; i++) q.push_back(8'($urandom));
            x = 8'd0;
            for (int i = 1; i < q.size(); i++) x = x ^ q[i];
            if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
            q.push_back(x);
        end
        if (kind == 0) begin
            x = 8'($urandom);
            if (x == SYNC) x = 8'h00;
            q.delete();
            q.push_back(x);
        end
        pos = $urandom_range(1, q.size());
        for (int i = 0; i < q.size(); i++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if (i == pos && kind == 3) gap = TO + $urandom_range(0, 2);
            if (i == pos && kind == 4) gap = TO - 1;
            idle_n(gap);
            sendb(q[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        phase = "reset";
        check_eq(phase, dut_vec(), model_vec());
        rst_n = 1'b1;

        // basic frame with ready high
        phase = "t1"; rdy_mode = 1;
        sendb(8'hA5); sendb(8'h10); sendb(8'h02); sendb(8'h33); sendb(8'h44); sendb(8'h65);
        check_eq("t1_valid", 64'(cmd_valid), 64'd1);
        check_eq("t1_payload", 64'(payload), 64'h0000_4433);
        idle_n(2);
        check_eq("t1_valid_gone", 64'(cmd_valid), 64'd0);

        // zero-length frame, then a checksum error
        phase = "t2";
        sendb(8'hA5); sendb(8'h20); sendb(8'h00); sendb(8'h20);
        check_eq("t2_cmd", 64'(cmd), 64'h20);
        sendb(8'hA5); sendb(8'h20); sendb(8'h00); sendb(8'h23);
        check_eq("t2_errchk", 64'(err_chk), 64'd1);
        idle_n(2);

        // length error, junk, then a good frame
        phase = "t3";
        sendb(8'hA5); sendb(8'h30); sendb(8'h05);
        check_eq("t3_errlen", 64'({err_len, busy}), 64'b10);
        sendb(8'h00); sendb(8'hA5); sendb(8'h31); sendb(8'h00); sendb(8'h31);
        check_eq("t3_cmd", 64'({cmd_valid, cmd}), 64'h131);
        idle_n(2);

        // timeout, then a byte exactly on the expiry cycle
        phase = "t4"; rdy_mode = 0;
        sendb(8'hA5); sendb(8'h40);
        idle_n(TO);
        check_eq("t4_timeout", 64'({err_to, busy}), 64'b10);
        sendb(8'hA5); sendb(8'h40);
        idle_n(TO - 1);
        sendb(8'h00);
        check_eq("t4_no_timeout", 64'({err_to, busy}), 64'b01);
        sendb(8'h40);
        idle_n(2);

        // overrun with ready low, then a replacement load on acceptance
        phase = "t5"; rdy_mode = 1;
        idle_n(2);
        rdy_mode = 2;
        sendb(8'hA5); sendb(8'h50); sendb(8'h00); sendb(8'h50);
        sendb(8'hA5); sendb(8'h51); sendb(8'h00); sendb(8'h51);
        check_eq("t5_overrun", 64'({err_ovr, cmd}), 64'h150);
        sendb(8'hA5); sendb(8'h52); sendb(8'h00);
        step(1'b1, 8'h52, 1'b1);
        check_eq("t5_replace", 64'({cmd_valid, cmd}), 64'h152);
        idle_n(2);

        // reset mid-payload while a frame is held
        phase = "t6";
        sendb(8'hA5); sendb(8'h60); sendb(8'h03); sendb(8'h11);
        @(negedge clk);
        rst_n = 1'b0; rx_dv = 1'b0;
        #1;
        model_reset();
        check_eq("t6_async_reset", dut_vec(), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        sendb(8'hA5); sendb(8'h61); sendb(8'h01); sendb(8'h77); sendb(8'h61 ^ 8'h01 ^ 8'h77);
        check_eq("t6_fresh", 64'({cmd_valid, cmd, len, payload}), {20'd0, 1'b1, 8'h61, 3'd1, 32'h0000_0077});

        // random traffic
        phase = "random"; rdy_mode = 0;
        for (int f = 0; f < 300; f++) random_frame();
        idle_n(TO + 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
